// File: rtl/ddc_config_sequencer_if.sv
// Host-buffer, control/status and distributor signals of the DDC config sequencer.
// master: the sequencer itself; slave: whatever drives the host side and the distributor.
interface ddc_config_sequencer_if #(
    parameter int CONFIG_WIDTH = 32,
    parameter int ADDR_WIDTH   = 11
);
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [CONFIG_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]     cfg_len;
    logic                    start;
    logic                    busy;
    logic                    done_pulse;
    logic [2:0]              status;
    logic                    wr_drop;
    logic                    isConfig;
    logic [CONFIG_WIDTH-1:0] Data_Config_Out;
    logic                    isConfigACK;
    logic                    isConfigDone;

    modport master (
        input  wr_en, wr_addr, wr_data, cfg_len, start, isConfigACK, isConfigDone,
        output busy, done_pulse, status, wr_drop, isConfig, Data_Config_Out
    );

    modport slave (
        output wr_en, wr_addr, wr_data, cfg_len, start, isConfigACK, isConfigDone,
        input  busy, done_pulse, status, wr_drop, isConfig, Data_Config_Out
    );
endinterface

// File: rtl/ddc_config_sequencer.sv
// Plays a host-written configuration image to the DDC filter-config distributor
// as an isConfig strobe plus a gap-free word stream, then supervises ACK/Done.
module ddc_config_sequencer #(
    parameter int CONFIG_WIDTH = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                     CLK,
    input  logic                     nRST,
    ddc_config_sequencer_if.master   cfg_if,
    output logic [2:0]               dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFETCH  = 3'd1,
        S_STROBE    = 3'd2,
        S_STREAM    = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam int            LW      = ADDR_WIDTH + 1;
    localparam int            TW      = $clog2(DONE_TIMEOUT) + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(2 ** ADDR_WIDTH);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_NOACK   = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd2;
    localparam logic [2:0] ST_EARLY   = 3'd3;
    localparam logic [2:0] ST_BAD_LEN = 3'd4;

    state_t                  state_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           cnt_q;
    logic [TW-1:0]           wait_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [CONFIG_WIDTH-1:0] stage_q;
    logic [CONFIG_WIDTH-1:0] data_q;
    logic                    isc_q;
    logic                    busy_q;
    logic                    done_q;
    logic [2:0]              status_q;
    logic                    drop_q;

    logic [CONFIG_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [CONFIG_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic                    len_ok;

    // Word 0 is read while still in IDLE so the stream can start two cycles later.
    assign ram_raddr = (state_q == S_IDLE) ? '0 : rd_addr_q;
    assign len_ok    = (cfg_if.cfg_len != '0) && (cfg_if.cfg_len <= LEN_MAX);

    // Image buffer: contents are not reset; same-address read/write returns old data.
    always_ff @(posedge CLK) begin
        if (cfg_if.wr_en && !busy_q) begin
            mem[cfg_if.wr_addr] <= cfg_if.wr_data;
        end
        rd_data_q <= mem[ram_raddr];
    end

    // ACK is a level checked only in the first stream cycle; Done is a pulse that is
    // success in WAIT_DONE and an abort if it arrives before the last stream word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            rd_addr_q <= '0;
            stage_q   <= '0;
            data_q    <= '0;
            isc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= ST_OK;
            drop_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            isc_q   <= 1'b0;
            stage_q <= rd_data_q;
            if (cfg_if.wr_en && busy_q) begin
                drop_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cfg_if.start) begin
                        busy_q <= 1'b1;
                        if (len_ok) begin
                            len_q     <= cfg_if.cfg_len;
                            drop_q    <= 1'b0;
                            rd_addr_q <= ADDR_WIDTH'(1);
                            state_q   <= S_PREFETCH;
                        end else begin
                            status_q <= ST_BAD_LEN;
                            done_q   <= 1'b1;
                            state_q  <= S_FINISH;
                        end
                    end
                end

                S_PREFETCH: begin
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                    isc_q     <= 1'b1;
                    state_q   <= S_STROBE;
                end

                S_STROBE: begin
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                    data_q    <= stage_q;
                    cnt_q     <= '0;
                    state_q   <= S_STREAM;
                end

                S_STREAM: begin
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                    if ((cnt_q == '0) && !cfg_if.isConfigACK) begin
                        data_q   <= '0;
                        status_q <= ST_NOACK;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else if (cnt_q == len_q - LW'(1)) begin
                        data_q  <= '0;
                        wait_q  <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (cfg_if.isConfigDone) begin
                        data_q   <= '0;
                        status_q <= ST_EARLY;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else begin
                        data_q <= stage_q;
                        cnt_q  <= cnt_q + LW'(1);
                    end
                end

                S_WAIT_DONE: begin
                    // Done in the limit cycle wins over the timeout.
                    if (cfg_if.isConfigDone) begin
                        status_q <= ST_OK;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else if (wait_q == TW'(DONE_TIMEOUT - 1)) begin
                        status_q <= ST_TIMEOUT;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end

                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    data_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_if.busy            = busy_q;
    assign cfg_if.done_pulse      = done_q;
    assign cfg_if.status          = status_q;
    assign cfg_if.wr_drop         = drop_q;
    assign cfg_if.isConfig        = isc_q;
    assign cfg_if.Data_Config_Out = data_q;
    assign dbg_state_o            = state_q;
endmodule
